// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial bit-pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [4:0] PAT_DEF_10010 = 5'b10010;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle between a pattern requester and seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int unsigned PAT_W = 5,
  parameter int unsigned CNT_W = 4
);

  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_cnt;
  logic             gap_en;
  logic             abort;
  logic             j;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, use_def, pat_in, rep_cnt, gap_en, abort,
    input  j, valid, busy, done
  );

  modport slave (
    input  start, use_def, pat_in, rep_cnt, gap_en, abort,
    output j, valid, busy, done
  );

endinterface

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first. Exposes the MSB it will hold after
// the coming edge so the owner can register the serial bit without an extra cycle.
module piso_shreg #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_msb_next
);

  logic [PAT_W-1:0] r_data;
  logic [PAT_W-1:0] w_data_d;

  always_comb begin
    w_data_d = r_data;
    if (i_load) begin
      w_data_d = i_data;
    end else if (i_shift) begin
      w_data_d = {r_data[PAT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_d;
    end
  end

  assign o_msb_next = w_data_d[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched word MSB first, repeated rep_cnt times,
// with an optional one-cycle idle gap between repetitions. All outputs are registered.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PAT_DEF = PAT_DEF_10010,
  parameter int unsigned      CNT_W   = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IdxMsb = IDX_W'(PAT_W - 1);

  state_e           r_state, w_state_d;
  logic [PAT_W-1:0] r_pat, w_pat_d;
  logic [CNT_W-1:0] r_rep, w_rep_d;
  logic             r_gap, w_gap_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic             r_j, r_valid, r_busy, r_done;
  logic             w_j_d, w_valid_d, w_busy_d, w_done_d;

  logic             w_load, w_shift;
  logic [PAT_W-1:0] w_load_data;
  logic             w_msb_next;

  piso_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (w_load_data),
    .o_msb_next (w_msb_next)
  );

  always_comb begin
    w_state_d   = r_state;
    w_pat_d     = r_pat;
    w_rep_d     = r_rep;
    w_gap_d     = r_gap;
    w_idx_d     = r_idx;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_data = r_pat;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (bus.rep_cnt != '0) begin
            w_pat_d     = bus.use_def ? PAT_DEF : bus.pat_in;
            w_load_data = w_pat_d;
            w_load      = 1'b1;
            w_rep_d     = bus.rep_cnt;
            w_gap_d     = bus.gap_en;
            w_idx_d     = IdxMsb;
            w_state_d   = StShift;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StShift: begin
        if (bus.abort) begin
          w_state_d = StIdle;
        end else if (r_idx != '0) begin
          w_shift = 1'b1;
          w_idx_d = r_idx - 1'b1;
        end else begin
          // LSB is on the wire this cycle: close out this repetition.
          if (r_rep != '0) begin
            w_rep_d = r_rep - 1'b1;
          end
          if (r_rep <= CNT_W'(1)) begin
            w_state_d = StDone;
          end else begin
            w_load    = 1'b1;
            w_idx_d   = IdxMsb;
            w_state_d = r_gap ? StGap : StShift;
          end
        end
      end
      StGap: begin
        w_state_d = bus.abort ? StIdle : StShift;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_valid_d = (w_state_d == StShift);
    w_j_d     = w_valid_d & w_msb_next;
    w_busy_d  = (w_state_d == StShift) || (w_state_d == StGap);
    w_done_d  = (w_state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_pat   <= '0;
      r_rep   <= '0;
      r_gap   <= 1'b0;
      r_idx   <= '0;
      r_j     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pat   <= w_pat_d;
      r_rep   <= w_rep_d;
      r_gap   <= w_gap_d;
      r_idx   <= w_idx_d;
      r_j     <= w_j_d;
      r_valid <= w_valid_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign bus.j     = r_j;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed cases plus random transfers, each checked cycle by
// cycle against an expected stream computed from pattern, repetition and gap arithmetic.
module tb_seq_pattern_tx;

  localparam int PW = 5;
  localparam int CW = 4;
  localparam logic [PW-1:0] DEF_PAT = 5'b10010;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  seq_pattern_tx_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

  seq_pattern_tx #(
    .PAT_W   (PW),
    .PAT_DEF (DEF_PAT),
    .CNT_W   (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit ej, input bit ev, input bit eb,
                            input bit ed);
    check_eq({tag, " j"},     32'(bus.j),     32'(ej));
    check_eq({tag, " valid"}, 32'(bus.valid), 32'(ev));
    check_eq({tag, " busy"},  32'(bus.busy),  32'(eb));
    check_eq({tag, " done"},  32'(bus.done),  32'(ed));
  endtask

  function automatic int stream_len(input int rep, input bit gap);
    return (rep == 0) ? 0 : rep * PW + (gap ? rep - 1 : 0);
  endfunction

  // Entered and left at 1 ns after a rising edge. Cycle 0 carries start.
  task automatic run_xfer(input logic [PW-1:0] pat, input bit ud, input int rep,
                          input bit gap, input int abort_at, input bit poke);
    logic [PW-1:0] ep;
    int stream, period, last, t, pos;
    bit ej, ev, eb, ed;
    ep     = ud ? DEF_PAT : pat;
    stream = stream_len(rep, gap);
    period = PW + (gap ? 1 : 0);
    last   = ((abort_at > 0) ? abort_at + 1 : stream + 1) + 2;

    bus.start   = 1'b1;
    bus.use_def = ud;
    bus.pat_in  = pat;
    bus.rep_cnt = CW'(rep);
    bus.gap_en  = gap;
    bus.abort   = 1'b0;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.use_def = 1'($urandom);
    bus.pat_in  = PW'($urandom);
    bus.rep_cnt = CW'($urandom);
    bus.gap_en  = 1'($urandom);

    for (int c = 1; c <= last; c++) begin
      bus.abort = (c == abort_at);
      bus.start = poke && (c <= stream + 1) && (abort_at == 0 || c <= abort_at)
                  && ($urandom_range(0, 1) == 1);
      ej = 0; ev = 0; eb = 0; ed = 0;
      t  = c - 1;
      if (abort_at > 0 && c > abort_at) begin
        // idle after abort, no done
      end else if (c == stream + 1) begin
        ed = 1;
      end else if (c <= stream) begin
        pos = t % period;
        eb  = 1;
        if (pos < PW) begin
          ev = 1;
          ej = ep[PW-1-pos];
        end
      end
      @(negedge clk);
      check_outs($sformatf("p%0h r%0d g%0d a%0d c%0d", ep, rep, gap, abort_at, c),
                 ej, ev, eb, ed);
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    int rep, ab;
    bit gap;
    n_checks = 0;
    n_errors = 0;

    // Reset held with start asserted: everything stays quiet.
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.use_def = 1'b1;
    bus.pat_in  = '0;
    bus.rep_cnt = CW'(1);
    bus.gap_en  = 1'b0;
    bus.abort   = 1'b0;
    #8;
    check_outs("in reset", 0, 0, 0, 0);
    #2;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_outs("after reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;

    run_xfer(5'b00000, 1, 1, 0, 0, 0);
    run_xfer(5'b10110, 0, 2, 0, 0, 0);
    run_xfer(5'b00000, 1, 3, 1, 0, 0);
    run_xfer(5'b11111, 0, 0, 0, 0, 0);
    run_xfer(5'b10110, 0, 2, 1, 0, 1);
    run_xfer(5'b00000, 1, 2, 0, 3, 0);
    run_xfer(5'b01101, 0, 2, 1, 6, 0);

    // Reset mid-transfer clears outputs without waiting for a clock edge.
    bus.start   = 1'b1;
    bus.use_def = 1'b0;
    bus.pat_in  = 5'b11011;
    bus.rep_cnt = CW'(2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    check_outs("pre-rst", 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    check_outs("async rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_outs($sformatf("post-rst c%0d", c), 0, 0, 0, 0);
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 40; k++) begin
      rep = $urandom_range(0, 4);
      gap = 1'($urandom);
      ab  = 0;
      if (rep != 0 && $urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, stream_len(rep, gap));
      end
      run_xfer(PW'($urandom), 1'($urandom), rep, gap, ab, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
